// File: rtl/fib_seq_pkg.sv
// -----------------------------------------------------------------------------
// fib_seq_pkg
//   Shared definitions for the recursive-sequence controller:
//     - default sizing constants (index width, largest legal entry, watchdog
//       limits and watchdog counter width)
//     - controller state encoding
//     - datapath strobe bundle and the state -> strobe decode used by the FSM
// -----------------------------------------------------------------------------
package fib_seq_pkg;

  localparam int SIZE_DEF      = 4;     // index width, result is 2*SIZE
  localparam int MAX_ENTRY_DEF = 14;    // value table holds entries 0..14
  localparam int WAIT_MAX_DEF  = 15;    // cycles allowed waiting on one ack
  localparam int RUN_MAX_DEF   = 4095;  // cycles allowed for a whole job
  localparam int WD_W_DEF      = 12;    // watchdog counter width

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    EXPAND  = 4'd2,
    ALU     = 4'd3,
    DESCEND = 4'd4,
    CALC    = 4'd5,
    CHECK   = 4'd6,
    POP     = 4'd7,
    FINISH  = 4'd8
  } state_e;

  // One bit per datapath control pin.
  typedef struct packed {
    logic load_init;
    logic updater;
    logic alu;
    logic push;
    logic res_updater;
    logic cal_res;
    logic poping;
    logic dont_check;
  } strobe_t;

  // Moore decode of the datapath strobes. dont_check is the only pin that
  // idles high: the datapath compares its stack only while it is low.
  function automatic strobe_t decode_strobes(input state_e st);
    strobe_t s;
    s            = '0;
    s.dont_check = 1'b1;
    case (st)
      LOAD:    s.load_init   = 1'b1;
      EXPAND:  s.updater     = 1'b1;
      ALU: begin
        s.alu  = 1'b1;
        s.push = 1'b1;
      end
      DESCEND: s.res_updater = 1'b1;
      CALC:    s.cal_res     = 1'b1;
      CHECK:   s.dont_check  = 1'b0;
      POP:     s.poping      = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fib_seq_controller_seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
//   Saturating cycle counter with synchronous clear and count enable. expire_o
//   flags the LIMIT-th consecutive enabled cycle (and every enabled cycle after
//   it), so a caller can abort on the same edge that would have been the
//   LIMIT-th cycle spent in the watched condition.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-low
//   clear_i   in   return the count to zero (has priority over enable_i)
//   enable_i  in   count this cycle
//   expire_o  out  limit reached while enabled
// -----------------------------------------------------------------------------
module seq_watchdog #(
  parameter int W     = 12,
  parameter int LIMIT = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [W-1:0] LIM    = W'(LIMIT);
  localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIM)) begin
      // Stops at LIM rather than wrapping, so a stuck job can never see the
      // count fall back under the limit.
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of enabled cycles already completed, so the
  // current cycle is the LIMIT-th one when count_q == LIMIT-1.
  assign expire_o = enable_i && (count_q >= LIM_M1);

endmodule

// File: rtl/fib_seq_controller.sv
// -----------------------------------------------------------------------------
// fib_seq_controller
//   Sequencer for the stack-based evaluator of
//     v(n) = 2*v(n-1) + 3*v(n-2),  v(0) = v(1) = 1.
//   Accepts a job (entry index), walks the datapath through
//   LOAD -> EXPAND/ALU/DESCEND (descend to the base) -> CALC/CHECK/POP
//   (unwind), captures the datapath result and hands it back over a
//   valid/ready handshake. Trivial (entry <= 1) and illegal entries are
//   answered without touching the datapath. Two watchdogs abort a job that
//   waits too long on one acknowledge or runs too long overall.
//
// Ports:
//   clk, rst                 clock / synchronous active-low reset
//   start, entry_in          job request (sampled only in IDLE) and index
//   busy                     high from acceptance until the result is taken
//   out_valid, out_ready     result handshake
//   out_result, out_err      captured result, abort flag
//   entry                    latched index to the datapath
//   load_init .. dont_check  datapath strobes (Moore, registered)
//   updated, cal_update,
//   backtrack, done          datapath status
//   dp_result                datapath result bus
// -----------------------------------------------------------------------------
module fib_seq_controller
  import fib_seq_pkg::*;
#(
  parameter int SIZE      = SIZE_DEF,
  parameter int MAX_ENTRY = MAX_ENTRY_DEF,
  parameter int WAIT_MAX  = WAIT_MAX_DEF,
  parameter int RUN_MAX   = RUN_MAX_DEF,
  parameter int WD_W      = WD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  // request / response
  input  logic                start,
  input  logic [SIZE-1:0]     entry_in,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*SIZE-1:0]   out_result,
  output logic                out_err,
  // datapath control
  output logic [SIZE-1:0]     entry,
  output logic                load_init,
  output logic                updater,
  output logic                alu,
  output logic                push,
  output logic                res_updater,
  output logic                cal_res,
  output logic                poping,
  output logic                dont_check,
  // datapath status
  input  logic                updated,
  input  logic                cal_update,
  input  logic                backtrack,
  input  logic                done,
  input  logic [2*SIZE-1:0]   dp_result
);

  localparam int              RES_W = 2 * SIZE;
  localparam logic [SIZE-1:0] MAX_E = SIZE'(MAX_ENTRY);
  localparam logic [SIZE-1:0] ONE_E = SIZE'(1);

  state_e            state_q;
  state_e            state_d;
  logic [SIZE-1:0]   entry_q;
  logic              busy_q;
  logic              valid_q;
  logic              err_q;
  logic              err_d;
  logic [RES_W-1:0]  result_q;
  logic [RES_W-1:0]  result_d;
  strobe_t           strobe_q;

  logic              ack_wait;   // waiting on updated / cal_update
  logic              running;    // job owns the datapath
  logic              ack_expire;
  logic              run_expire;

  assign ack_wait = (state_q == EXPAND) || (state_q == CALC);
  assign running  = (state_q != IDLE) && (state_q != FINISH);

  // ---------------------------------------------------------------------------
  // Watchdogs. Leaving the watched condition clears each counter, so the
  // acknowledge count restarts on every visit to EXPAND/CALC (the FSM always
  // passes through another state between two visits) and the run count
  // restarts with each job.
  // ---------------------------------------------------------------------------
  seq_watchdog #(
    .W     (WD_W),
    .LIMIT (WAIT_MAX)
  ) u_ack_wd (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!ack_wait),
    .enable_i (ack_wait),
    .expire_o (ack_expire)
  );

  seq_watchdog #(
    .W     (WD_W),
    .LIMIT (RUN_MAX)
  ) u_run_wd (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!running),
    .enable_i (running),
    .expire_o (run_expire)
  );

  // ---------------------------------------------------------------------------
  // Next-state / result selection
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (entry_in > MAX_E) begin
            state_d  = FINISH;
            err_d    = 1'b1;
            result_d = '0;
          end else if (entry_in <= ONE_E) begin
            // Base cases are answered directly; the datapath stays idle.
            state_d  = FINISH;
            err_d    = 1'b0;
            result_d = RES_W'(1);
          end else begin
            state_d  = LOAD;
            err_d    = 1'b0;
            result_d = '0;
          end
        end
      end

      LOAD:    state_d = EXPAND;

      EXPAND:  if (updated) state_d = ALU;

      // backtrack tells us the pushed frame reached the base case, so the
      // next step is to combine values instead of descending further.
      ALU:     state_d = backtrack ? CALC : DESCEND;

      DESCEND: state_d = EXPAND;

      CALC:    if (cal_update) state_d = CHECK;

      CHECK: begin
        if (done) begin
          state_d  = FINISH;
          err_d    = 1'b0;
          result_d = dp_result;
        end else begin
          state_d  = POP;
        end
      end

      POP:     state_d = ALU;

      FINISH: begin
        // start is deliberately not looked at here: a request presented
        // together with out_ready must be repeated once back in IDLE.
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // An abort overrides whatever the case statement chose, including an
    // acknowledge or a done arriving in the same cycle.
    if (running && (run_expire || (ack_wait && ack_expire))) begin
      state_d  = FINISH;
      err_d    = 1'b1;
      result_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Every output is registered from the
  // next-state value, so it always matches the Moore decode of state_q.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      entry_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      strobe_q <= decode_strobes(IDLE);
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      result_q <= result_d;
      busy_q   <= (state_d != IDLE);
      valid_q  <= (state_d == FINISH);
      strobe_q <= decode_strobes(state_d);
      if ((state_q == IDLE) && start) begin
        entry_q <= entry_in;
      end
    end
  end

  assign busy        = busy_q;
  assign out_valid   = valid_q;
  assign out_err     = err_q;
  assign out_result  = result_q;
  assign entry       = entry_q;

  assign load_init   = strobe_q.load_init;
  assign updater     = strobe_q.updater;
  assign alu         = strobe_q.alu;
  assign push        = strobe_q.push;
  assign res_updater = strobe_q.res_updater;
  assign cal_res     = strobe_q.cal_res;
  assign poping      = strobe_q.poping;
  assign dont_check  = strobe_q.dont_check;

endmodule

// File: tb/tb_fib_seq_controller.sv
// -----------------------------------------------------------------------------
// tb_fib_seq_controller
//   Drives jobs into fib_seq_controller against a behavioural datapath model,
//   keeps a scoreboard of expected {err, result}, watches the strobe sequence
//   and reports one line per job plus one summary line.
// -----------------------------------------------------------------------------
module tb_fib_seq_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] entry_in = '0;
  logic       busy;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic       out_err;
  logic [3:0] entry;
  logic       load_init, updater, alu, push, res_updater, cal_res, poping, dont_check;
  logic       updated, cal_update, backtrack, done;
  logic [7:0] dp_result;

  always #5 clk = ~clk;

  fib_seq_controller dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .entry_in    (entry_in),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_err     (out_err),
    .entry       (entry),
    .load_init   (load_init),
    .updater     (updater),
    .alu         (alu),
    .push        (push),
    .res_updater (res_updater),
    .cal_res     (cal_res),
    .poping      (poping),
    .dont_check  (dont_check),
    .updated     (updated),
    .cal_update  (cal_update),
    .backtrack   (backtrack),
    .done        (done),
    .dp_result   (dp_result)
  );

  // ---------------------------------------------------------------------------
  // Behavioural datapath: k tracks the descent index, (a, b) = (v(p-1), v(p-2))
  // while unwinding, p is the next index to be computed.
  // ---------------------------------------------------------------------------
  logic [3:0] k_m;
  logic [4:0] p_m;
  logic [7:0] a_m, b_m;
  int         upd_c = 0, cal_c = 0;
  int         upd_dly = 1, cal_dly = 1;
  bit         dp_upd_en = 1'b1;

  always @(posedge clk) begin
    upd_c <= updater ? upd_c + 1 : 0;
    cal_c <= cal_res ? cal_c + 1 : 0;
    if (load_init) begin
      k_m <= entry;
      a_m <= 8'd1;
      b_m <= 8'd1;
      p_m <= 5'd2;
    end
    if (res_updater) k_m <= k_m - 4'd1;
    if (cal_res && cal_update) begin
      a_m <= 8'(2 * a_m + 3 * b_m);
      b_m <= a_m;
      p_m <= p_m + 5'd1;
    end
  end

  assign updated    = dp_upd_en && updater && (upd_c >= upd_dly);
  assign cal_update = cal_res && (cal_c >= cal_dly);
  assign backtrack  = alu && (k_m <= 4'd2);
  assign done       = !dont_check && (p_m > {1'b0, entry});
  assign dp_result  = a_m;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] ref_v(input int n);
    logic [7:0] a, b, t;
    a = 8'd1;
    b = 8'd1;
    for (int i = 2; i <= n; i++) begin
      t = 8'(2 * a + 3 * b);
      b = a;
      a = t;
    end
    return a;
  endfunction

  typedef struct packed {
    logic       err;
    logic [7:0] res;
  } exp_t;
  exp_t sb[$];

  // ---------------------------------------------------------------------------
  // Strobe-sequence monitor. Phases: 0 idle, 1 load, 2 expand, 3 alu,
  // 4 descend, 5 calc, 6 check, 7 pop, 8 finish.
  // ---------------------------------------------------------------------------
  int seq_err = 0, load_cnt = 0, upd_cycles = 0, prev_ph = 0;
  bit rst_at_edge = 1'b1;

  always @(posedge clk) rst_at_edge <= !rst;

  function automatic int phase_of();
    if (load_init)   return 1;
    if (updater)     return 2;
    if (alu)         return 3;
    if (res_updater) return 4;
    if (cal_res)     return 5;
    if (!dont_check) return 6;
    if (poping)      return 7;
    if (out_valid)   return 8;
    return 0;
  endfunction

  function automatic int n_strobes();
    return int'(load_init) + int'(updater) + int'(alu) + int'(res_updater)
         + int'(cal_res) + int'(poping) + int'(!dont_check);
  endfunction

  function automatic bit legal(input int p, input int n);
    if (n == p) return (p == 0) || (p == 2) || (p == 5) || (p == 8);
    if (n == 8) return 1'b1;
    case (p)
      0:       return n == 1;
      1:       return n == 2;
      2:       return n == 3;
      3:       return (n == 4) || (n == 5);
      4:       return n == 2;
      5:       return n == 6;
      6:       return n == 7;
      7:       return n == 3;
      8:       return n == 0;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_at_edge) begin
      if (phase_of() != 0) seq_err <= seq_err + 1;
      prev_ph <= 0;
    end else begin
      if ((n_strobes() > 1) || (alu != push) || !legal(prev_ph, phase_of()))
        seq_err <= seq_err + 1;
      prev_ph <= phase_of();
    end
    if (load_init) load_cnt   <= load_cnt + 1;
    if (updater)   upd_cycles <= upd_cycles + 1;
  end

  // ---------------------------------------------------------------------------
  // One job: request, latency check, optional stall with ignored start pulses,
  // scoreboard compare at the handshake, post-handshake checks.
  // ---------------------------------------------------------------------------
  task automatic run_job(input logic [3:0] e, input int hold);
    exp_t       x;
    logic [7:0] res0;
    int         loads0, cyc;
    bit         short_job;
    short_job = (e <= 4'd1) || (e > 4'd14);
    x.err = (e > 4'd14) || (!short_job && !dp_upd_en);
    x.res = x.err ? 8'd0 : ref_v(int'(e));
    sb.push_back(x);
    loads0 = load_cnt;

    start    = 1'b1;
    entry_in = e;
    @(negedge clk);
    start    = 1'b0;
    entry_in = 4'd0;
    check("busy_on_accept", busy, 1);
    check("entry_latched", entry, e);
    if (short_job) check("short_latency_valid", out_valid, 1);
    else           check("first_state_load", load_init, 1);

    cyc = 0;
    while (!out_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      check("valid_timeout", 0, 1);
      void'(sb.pop_front());
      return;
    end

    res0 = out_result;
    for (int i = 0; i < hold; i++) begin
      start    = (i % 2) == 0;
      entry_in = 4'd2;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, res0);
      check("hold_busy", busy, 1);
    end
    start    = 1'b0;
    entry_in = 4'd0;

    x = sb.pop_front();
    check("result", out_result, x.res);
    check("err", out_err, x.err);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_hs", out_valid, 0);
    check("busy_after_hs", busy, 0);
    check("load_init_count", load_cnt - loads0, short_job ? 1'b0 : 1'b1);
    check("strobe_sequence", seq_err, 0);
    $display("job entry=%0d result=%0d err=%0d expect=%0d/%0d", e, out_result, out_err, x.res, x.err);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int upd0, cyc;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_err", out_err, 0);
    check("rst_result", out_result, 0);
    check("rst_entry", entry, 0);
    check("rst_strobes", {load_init, updater, alu, push, res_updater, cal_res, poping, dont_check}, 8'h01);
    rst = 1'b1;
    @(negedge clk);

    run_job(4'd0, 0);
    run_job(4'd1, 0);
    run_job(4'd2, 0);
    run_job(4'd3, 0);
    run_job(4'd4, 0);
    run_job(4'd15, 0);

    // Datapath that never acknowledges the expand step.
    dp_upd_en = 1'b0;
    upd0 = upd_cycles;
    run_job(4'd3, 0);
    check("expand_cycles_before_abort", upd_cycles - upd0, 15);
    dp_upd_en = 1'b1;

    // Consumer stalls for 10 cycles while start is pulsed.
    run_job(4'd4, 10);

    // Reset in the middle of CALC.
    cal_dly  = 6;
    start    = 1'b1;
    entry_in = 4'd3;
    @(negedge clk);
    start    = 1'b0;
    cyc = 0;
    while (!cal_res && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_calc", cal_res, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midjob_rst_busy", busy, 0);
    check("midjob_rst_valid", out_valid, 0);
    check("midjob_rst_err", out_err, 0);
    check("midjob_rst_result", out_result, 0);
    check("midjob_rst_entry", entry, 0);
    check("midjob_rst_strobes", {load_init, updater, alu, push, res_updater, cal_res, poping, dont_check}, 8'h01);
    @(negedge clk);
    run_job(4'd3, 0);
    cal_dly = 1;

    // Longer jobs with varied acknowledge delays.
    upd_dly = 3;
    cal_dly = 2;
    run_job(4'd5, 0);
    run_job(4'd14, 2);
    upd_dly = 0;
    cal_dly = 0;
    run_job(4'd6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
